// File: rtl/pe_array_sched.sv
// Sequencer for a weight-stationary PE array: clears the PE weights, loads K weight
// columns, then streams ifmap columns pass by pass while counting bottom-edge psums.
module pe_array_sched #(
    parameter int G_ARRAY_HEIGHT = 5,
    parameter int G_ARRAY_WIDTH  = 4,
    parameter int G_KERNEL_SIZE  = 5,
    parameter int G_IMAGE_HEIGHT = 28,
    parameter int G_IMAGE_WIDTH  = 28,
    localparam int LP_LANES = G_ARRAY_HEIGHT + G_ARRAY_WIDTH - 1,
    localparam int LP_KW    = (G_KERNEL_SIZE > 1) ? $clog2(G_KERNEL_SIZE) : 1,
    localparam int LP_CW    = (G_IMAGE_WIDTH > 1) ? $clog2(G_IMAGE_WIDTH) : 1,
    localparam int LP_RW    = (G_IMAGE_HEIGHT > 1) ? $clog2(G_IMAGE_HEIGHT) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     ifmap_rdy_i,
    input  logic [G_ARRAY_WIDTH-1:0] psum_vld_i,
    output logic                     weight_clr_o,
    output logic                     weight_vld_o,
    output logic [LP_KW-1:0]         wt_idx_o,
    output logic [LP_LANES-1:0]      ifmap_vld_o,
    output logic [LP_LANES-1:0]      ifmap_row_o,
    output logic [LP_CW-1:0]         ifmap_col_o,
    output logic [LP_RW-1:0]         row_base_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int LP_OH = G_IMAGE_HEIGHT - G_KERNEL_SIZE + 1;
    localparam int LP_OW = G_IMAGE_WIDTH - G_KERNEL_SIZE + 1;
    localparam int LP_NW = $clog2(LP_OW + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t                               state_q, state_d;
    logic [LP_KW-1:0]                     wt_q, wt_d;
    logic [LP_CW-1:0]                     col_q, col_d;
    logic [LP_RW-1:0]                     rb_q, rb_d;
    logic [G_ARRAY_WIDTH-1:0][LP_NW-1:0]  cnt_q, cnt_d;
    logic [G_ARRAY_WIDTH-1:0]             act;
    logic [LP_LANES-1:0]                  lane_ok;
    logic                                 all_done;
    logic                                 last_pass;

    // Lanes past the image bottom and columns past the last output row sit idle.
    always_comb begin
        lane_ok  = '0;
        act      = '0;
        all_done = 1'b1;
        for (int i = 0; i < LP_LANES; i++)
            lane_ok[i] = (int'(rb_q) + i) < G_IMAGE_HEIGHT;
        for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
            act[c] = (int'(rb_q) + c) < LP_OH;
            if (act[c] && cnt_q[c] != LP_NW'(LP_OW))
                all_done = 1'b0;
        end
    end

    assign last_pass = (int'(rb_q) + G_ARRAY_WIDTH) >= LP_OH;

    always_comb begin
        state_d      = state_q;
        wt_d         = wt_q;
        col_d        = col_q;
        rb_d         = rb_q;
        cnt_d        = cnt_q;
        weight_clr_o = 1'b0;
        weight_vld_o = 1'b0;
        wt_idx_o     = '0;
        ifmap_vld_o  = '0;
        done_o       = 1'b0;

        if (state_q == S_STREAM || state_q == S_DRAIN) begin
            for (int c = 0; c < G_ARRAY_WIDTH; c++)
                if (psum_vld_i[c] && act[c] && cnt_q[c] != LP_NW'(LP_OW))
                    cnt_d[c] = cnt_q[c] + LP_NW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i)
                    state_d = S_CLEAR;
            end
            S_CLEAR: begin
                weight_clr_o = 1'b1;
                rb_d         = '0;
                col_d        = '0;
                wt_d         = '0;
                cnt_d        = '0;
                state_d      = S_LOAD_W;
            end
            S_LOAD_W: begin
                weight_vld_o = 1'b1;
                wt_idx_o     = wt_q;
                if (wt_q == LP_KW'(G_KERNEL_SIZE - 1)) begin
                    wt_d    = '0;
                    state_d = S_STREAM;
                end else begin
                    wt_d = wt_q + LP_KW'(1);
                end
            end
            S_STREAM: begin
                if (ifmap_rdy_i) begin
                    ifmap_vld_o = lane_ok;
                    if (col_q == LP_CW'(G_IMAGE_WIDTH - 1)) begin
                        col_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        col_d = col_q + LP_CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Clearing here overrides any psum landing on the same edge.
                if (all_done) begin
                    cnt_d = '0;
                    if (last_pass) begin
                        state_d = S_DONE;
                    end else begin
                        rb_d    = rb_q + LP_RW'(G_ARRAY_WIDTH);
                        state_d = S_STREAM;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ifmap_row_o = ifmap_vld_o & {LP_LANES{col_q == '0}};
    assign ifmap_col_o = col_q;
    assign row_base_o  = rb_q;
    assign busy_o      = (state_q != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wt_q    <= '0;
            col_q   <= '0;
            rb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wt_q    <= wt_d;
            col_q   <= col_d;
            rb_q    <= rb_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pe_array_sched.sv
// Scoreboard bench: two lockstepped schedulers (28- and 26-row images) checked
// against an event list built from the pass/column arithmetic of a convolution.
module tb_pe_array_sched;

    localparam int K   = 5;
    localparam int W   = 4;
    localparam int IW  = 28;
    localparam int L   = 8;
    localparam int OW  = 24;
    localparam int IHA = 28;
    localparam int IHB = 26;
    localparam int WKW = 3;
    localparam int WCW = 5;
    localparam int WRW = 5;

    logic clk = 1'b0;
    logic rst, start, rdy;
    logic [W-1:0] psa, psb;

    logic a_clr, a_wv, a_busy, a_done;
    logic [WKW-1:0] a_wt;
    logic [L-1:0]   a_vld, a_row;
    logic [WCW-1:0] a_col;
    logic [WRW-1:0] a_rb;
    logic b_clr, b_wv, b_busy, b_done;
    logic [WKW-1:0] b_wt;
    logic [L-1:0]   b_vld, b_row;
    logic [WCW-1:0] b_col;
    logic [WRW-1:0] b_rb;

    always #5 clk = ~clk;

    pe_array_sched #(.G_IMAGE_HEIGHT(IHA)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ifmap_rdy_i(rdy), .psum_vld_i(psa),
        .weight_clr_o(a_clr), .weight_vld_o(a_wv), .wt_idx_o(a_wt),
        .ifmap_vld_o(a_vld), .ifmap_row_o(a_row), .ifmap_col_o(a_col),
        .row_base_o(a_rb), .busy_o(a_busy), .done_o(a_done));

    pe_array_sched #(.G_IMAGE_HEIGHT(IHB)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ifmap_rdy_i(rdy), .psum_vld_i(psb),
        .weight_clr_o(b_clr), .weight_vld_o(b_wv), .wt_idx_o(b_wt),
        .ifmap_vld_o(b_vld), .ifmap_row_o(b_row), .ifmap_col_o(b_col),
        .row_base_o(b_rb), .busy_o(b_busy), .done_o(b_done));

    // kind: 0 clear, 1 weight load, 2 ifmap column, 3 done
    typedef struct packed {
        logic [1:0]   k;
        logic [7:0]   a;
        logic [7:0]   rb;
        logic [L-1:0] v;
        logic [L-1:0] r;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    int  checks = 0;
    int  failures = 0;

    int  pcnt[W];
    bit  ps_active, got_done, zflag;
    int  pidx, rmode;

    function automatic ev_t mk(input int k, input int a, input int rb,
                               input logic [L-1:0] v, input logic [L-1:0] r);
        ev_t e;
        e.k = 2'(k); e.a = 8'(a); e.rb = 8'(rb); e.v = v; e.r = r;
        return e;
    endfunction

    function automatic void push(input int w, input ev_t e);
        if (w == 0) qa.push_back(e); else qb.push_back(e);
    endfunction

    // Expected event stream of one whole convolution for an image of ih rows.
    function automatic void push_run(input int w, input int ih);
        int oh, np, rb;
        logic [L-1:0] m;
        oh = ih - K + 1;
        np = (oh + W - 1) / W;
        push(w, mk(0, 0, 0, '0, '0));
        for (int k = 0; k < K; k++) push(w, mk(1, k, 0, '0, '0));
        for (int p = 0; p < np; p++) begin
            rb = p * W;
            m  = '0;
            for (int i = 0; i < L; i++) if (rb + i < ih) m[i] = 1'b1;
            for (int c = 0; c < IW; c++) push(w, mk(2, c, rb, m, (c == 0) ? m : '0));
        end
        push(w, mk(3, 0, 0, '0, '0));
    endfunction

    function automatic logic [W-1:0] bmask(input int p);
        logic [W-1:0] m;
        m = '0;
        for (int c = 0; c < W; c++) if (p * W + c < IHB - K + 1) m[c] = 1'b1;
        return m;
    endfunction

    function automatic void chk_ev(input int w, input ev_t got);
        ev_t exp;
        checks++;
        if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
            failures++;
            $display("FAIL unexpected_event dut%0d got=%h exp=none", w, got);
            return;
        end
        exp = (w == 0) ? qa.pop_front() : qb.pop_front();
        if (got !== exp) begin
            failures++;
            $display("FAIL event dut%0d got=%h exp=%h", w, got, exp);
        end
    endfunction

    function automatic void observe(input int w, input logic clr, input logic wv, input logic dn,
                                    input logic [WKW-1:0] wt, input logic [L-1:0] vld,
                                    input logic [L-1:0] row, input logic [WCW-1:0] col,
                                    input logic [WRW-1:0] rb);
        if (clr) chk_ev(w, mk(0, 0, 0, vld, row));
        if (wv) chk_ev(w, mk(1, int'(wt), int'(rb), vld, row));
        if (vld != '0 || row != '0) chk_ev(w, mk(2, int'(col), int'(rb), vld, row));
        if (dn) chk_ev(w, mk(3, 0, 0, vld, row));
        checks++;
        if (!rdy && vld != '0) begin
            failures++;
            $display("FAIL stall_vld dut%0d got=%h exp=0", w, vld);
        end
    endfunction

    always @(negedge clk) begin
        observe(0, a_clr, a_wv, a_done, a_wt, a_vld, a_row, a_col, a_rb);
        observe(1, b_clr, b_wv, b_done, b_wt, b_vld, b_row, b_col, b_rb);
    end

    task automatic zchk();
        checks++;
        if ({a_clr, a_wv, a_busy, a_done, a_wt, a_vld, a_row, a_col, a_rb} != '0) begin
            failures++;
            $display("FAIL reset_zero dutA got=%h exp=0",
                     {a_clr, a_wv, a_busy, a_done, a_wt, a_vld, a_row, a_col, a_rb});
        end
        checks++;
        if ({b_clr, b_wv, b_busy, b_done, b_wt, b_vld, b_row, b_col, b_rb} != '0) begin
            failures++;
            $display("FAIL reset_zero dutB got=%h exp=0",
                     {b_clr, b_wv, b_busy, b_done, b_wt, b_vld, b_row, b_col, b_rb});
        end
    endtask

    // One cycle: observe at negedge, drive inputs just after posedge.
    // Psums for a pass start once its column 0 is seen; every column gets OW-1
    // random pulses and then one shared final pulse, so both DUTs finish together.
    task automatic cyc(output bit col10);
        bit fin;
        @(negedge clk);
        if (zflag) begin zchk(); zflag = 1'b0; end
        if (a_done) got_done = 1'b1;
        col10 = (a_vld != '0) && (a_col == WCW'(10));
        if (a_vld != '0 && a_col == '0) begin
            ps_active = 1'b1;
            pidx++;
            for (int c = 0; c < W; c++) pcnt[c] = 0;
        end
        @(posedge clk);
        #1;
        case (rmode)
            0:       rdy = ~rdy;
            1:       rdy = ($urandom_range(0, 3) != 0);
            default: rdy = 1'b1;
        endcase
        psa = '0;
        if (ps_active) begin
            fin = 1'b1;
            for (int c = 0; c < W; c++) if (pcnt[c] < OW - 1) fin = 1'b0;
            if (fin) begin
                psa       = '1;
                ps_active = 1'b0;
            end else begin
                for (int c = 0; c < W; c++)
                    if (pcnt[c] < OW - 1 && $urandom_range(0, 2) != 0) begin
                        psa[c] = 1'b1;
                        pcnt[c]++;
                    end
            end
        end
        psb = psa & bmask(pidx);
    endtask

    task automatic do_run(input int mode, input bit hold, input int rst_pass);
        int n;
        bit rst_done, c10;
        n = 0; rst_done = 1'b0;
        rmode = mode; got_done = 1'b0; ps_active = 1'b0; pidx = -1;
        push_run(0, IHA);
        push_run(1, IHB);
        start = 1'b1;
        while (!got_done && n < 4000) begin
            cyc(c10);
            n++;
            if (!hold) start = 1'b0;
            if (rst) begin
                // Reset just took effect: restart immediately on the first free cycle.
                rst = 1'b0;
                start = 1'b1;
                qa.delete();
                qb.delete();
                push_run(0, IHA);
                push_run(1, IHB);
                ps_active = 1'b0;
                pidx = -1;
                psa = '0;
                psb = '0;
                zflag = 1'b1;
            end else if (rst_pass >= 0 && !rst_done && pidx == rst_pass && c10) begin
                rst = 1'b1;
                rst_done = 1'b1;
                ps_active = 1'b0;
                psa = '0;
                psb = '0;
            end
        end
        start = 1'b0;
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL done_timeout got=%0d cycles exp=done_o", n);
        end
        repeat (2) cyc(c10);
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b%b exp=00", a_busy, b_busy);
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=%0d/%0d exp=0/0", qa.size(), qb.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rdy = 1'b0; psa = '0; psb = '0;
        zflag = 1'b0; ps_active = 1'b0; pidx = -1; rmode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        zchk();
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_run(0, 1'b0, -1);   // rdy toggling every cycle
        do_run(1, 1'b0, -1);   // random rdy
        do_run(1, 1'b0, 2);    // reset during the third pass, then restart
        do_run(2, 1'b1, -1);   // start held high through the run
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_array_sched.md
PE_ARRAY_SCHED -- requirements
Module: pe_array_sched

Interface
REQ-001 Parameter G_ARRAY_HEIGHT, default 5: PE rows; SHALL equal G_KERNEL_SIZE.
REQ-002 Parameter G_ARRAY_WIDTH, default 4: PE columns, one output row per column per pass.
REQ-003 Parameter G_KERNEL_SIZE, default 5: square kernel dimension K.
REQ-004 Parameter G_IMAGE_HEIGHT / G_IMAGE_WIDTH, default 28 / 28: ifmap dimensions IH / IW.
REQ-005 Derived: L = G_ARRAY_HEIGHT+G_ARRAY_WIDTH-1 ifmap lanes; OH = IH-K+1; OW = IW-K+1; NP = ceil(OH/G_ARRAY_WIDTH) passes.
REQ-006 One clock and a synchronous active-high reset, named clk_i and rst_i.
REQ-007 clk_i  in  1  clock; all state updates on its rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 start_i  in  1  begin one full convolution; sampled only in IDLE.
REQ-010 ifmap_rdy_i  in  1  ifmap buffer can supply the current column this cycle.
REQ-011 psum_vld_i  in  G_ARRAY_WIDTH  per-column psum valid from the array bottom edge.
REQ-012 weight_clr_o  out  1  clear PE weight registers.
REQ-013 weight_vld_o  out  1  broadcast weight load strobe.
REQ-014 wt_idx_o  out  clog2(K)  kernel column being loaded.
REQ-015 ifmap_vld_o  out  L  per-lane ifmap valid; lane i carries image row base+i.
REQ-016 ifmap_row_o  out  L  per-lane start-of-row marker, asserted with column 0.
REQ-017 ifmap_col_o  out  clog2(IW)  image column requested from the buffer.
REQ-018 row_base_o  out  clog2(IH)  first image/output row of the current pass.
REQ-019 busy_o  out  1  high in every state except IDLE.
REQ-020 done_o  out  1  one-cycle pulse on completion.

Function
REQ-021 States SHALL be IDLE, CLEAR, LOAD_W, STREAM, DRAIN, DONE.
REQ-022 IDLE->CLEAR when start_i=1; start_i in any other state SHALL be ignored.
REQ-023 CLEAR SHALL last exactly 1 cycle with weight_clr_o=1, then ->LOAD_W; row_base_o SHALL be set to 0.
REQ-024 LOAD_W SHALL last exactly K cycles with weight_vld_o=1 and wt_idx_o=0,1,...,K-1, then ->STREAM.
REQ-025 In STREAM, when ifmap_rdy_i=1: ifmap_vld_o[i]=1 for every lane with row_base_o+i<IH (else 0), ifmap_col_o advances by 1 next cycle.
REQ-026 In STREAM, when ifmap_rdy_i=0: ifmap_vld_o=0, ifmap_row_o=0, ifmap_col_o holds (stall, no column skipped or repeated).
REQ-027 ifmap_row_o[i] SHALL equal ifmap_vld_o[i] AND (ifmap_col_o==0).
REQ-028 After column IW-1 is accepted, ifmap_col_o SHALL wrap to 0 and the state ->DRAIN.
REQ-029 Column c is active in a pass when row_base_o+c<OH; only active columns are counted.
REQ-030 A per-column counter SHALL increment on psum_vld_i[c] for active c in STREAM or DRAIN, saturating at OW; psum_vld_i on inactive columns or other states SHALL be ignored.
REQ-031 DRAIN->next pass when all active counters equal OW: counters clear, row_base_o += G_ARRAY_WIDTH, ->STREAM, weights not reloaded.
REQ-032 If row_base_o+G_ARRAY_WIDTH>=OH at that point (last pass), DRAIN->DONE instead.
REQ-033 DONE SHALL last 1 cycle with done_o=1, then ->IDLE; start_i in DONE SHALL be ignored.
REQ-034 weight_clr_o, weight_vld_o, ifmap_vld_o, ifmap_row_o SHALL be 0 outside their stated states.

Reset
REQ-035 rst_i=1 at any cycle, including mid-pass, SHALL force IDLE on the next edge with all outputs 0, counters 0, row_base_o=0, ifmap_col_o=0.
REQ-036 The first cycle after rst_i deasserts SHALL behave as IDLE; a start_i sampled then SHALL be honored.

Verification
REQ-037 Defaults, start_i pulse -> 1 cycle weight_clr_o, then 5 cycles weight_vld_o with wt_idx_o 0..4, then STREAM with ifmap_vld_o=8'hFF, ifmap_row_o=8'hFF at col 0.
REQ-038 ifmap_rdy_i toggling 1/0 each cycle in STREAM -> ifmap_col_o covers 0..27 exactly once each, 56 STREAM cycles, no vld on rdy=0 cycles.
REQ-039 Return 24 psum_vld_i pulses per column each pass -> 6 passes (row_base_o 0,4,...,20), done_o single pulse, then IDLE with busy_o=0.
REQ-040 G_IMAGE_HEIGHT=26 (OH=22): last pass row_base_o=20 -> only columns 0,1 counted; DONE reached with psum_vld_i[2:3] never asserted.
REQ-041 rst_i asserted mid-STREAM of pass 3 -> next cycle all outputs 0, row_base_o=0; later start_i restarts from CLEAR.
REQ-042 start_i held high through the run -> no restart before DONE; exactly one done_o pulse, and a new run begins only via IDLE.
